// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_BYTES_DEF = 1024;

  // The port that did not take the previous grant.
  function automatic logic otherPort(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way picker between fetch (I) and data (D).
// Build option MEM_ARB_RR_EN: a tie goes to the port not granted last.
// Without it, D always beats I so loads and stores never starve behind fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_iReq,
  input  logic i_dReq,
  input  logic i_last,
  output logic o_grant,
  output logic o_valid
);

`ifdef MEM_ARB_RR_EN
  // Round-robin: alternate on a tie, otherwise grant whoever is asking.
  always_comb begin
    o_valid = i_iReq | i_dReq;
    o_grant = PORT_I;
    if (i_iReq && i_dReq) begin
      o_grant = otherPort(i_last);
    end else if (i_dReq) begin
      o_grant = PORT_D;
    end
  end
`else
  logic w_unusedLast;
  assign w_unusedLast = i_last;

  // Fixed priority: D wins whenever it is requesting.
  always_comb begin
    o_valid = i_iReq | i_dReq;
    o_grant = PORT_I;
    if (i_dReq) begin
      o_grant = PORT_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed memory between instruction fetch (I)
// and data load/store (D). One access at a time: IDLE -> SERVE -> RESP.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking (default: D over I).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - 4);

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt;
  logic              r_rw;
  logic              r_legal;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_iRdata;
  logic [DATA_W-1:0] r_dRdata;
  logic [ADDR_W-1:0] w_reqAddr;
  logic [DATA_W-1:0] w_capture;
  logic              w_grant;
  logic              w_valid;
  logic              w_last;

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Remember who was granted most recently, updated on every grant.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_last <= PORT_I;
    end else if (r_state == IDLE && w_valid) begin
      r_last <= w_grant;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = PORT_I;
`endif

  mem_arb_pick u_pick (
    .i_iReq  (i_req),
    .i_dReq  (d_req),
    .i_last  (w_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_reqAddr = (w_grant == PORT_D) ? d_addr : i_addr;
  assign w_capture = r_legal ? mem_rdata : '0;
  assign i_rdata   = r_iRdata;
  assign d_rdata   = r_dRdata;

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the winner's request when leaving IDLE; range check is done here once.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_gnt   <= PORT_I;
      r_rw    <= 1'b0;
      r_legal <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_gnt   <= w_grant;
      r_rw    <= (w_grant == PORT_D) && d_rw;
      r_addr  <= w_reqAddr;
      r_legal <= (w_reqAddr <= LAST_LEGAL);
      r_wdata <= (w_grant == PORT_D) ? d_wdata : '0;
    end
  end

  // Capture memory read data for the winner at the end of SERVE; illegal reads give 0.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_iRdata <= '0;
      r_dRdata <= '0;
    end else if (r_state == SERVE) begin
      if (r_gnt == PORT_D) begin
        r_dRdata <= w_capture;
      end else begin
        r_iRdata <= w_capture;
      end
    end
  end

  // Next state, memory pins (driven only in SERVE) and the done/err pulse in RESP.
  always_comb begin
    w_next    = r_state;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    d_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next = SERVE;
        end
      end
      SERVE: begin
        w_next    = RESP;
        mem_rw    = r_rw && r_legal;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      RESP: begin
        w_next = IDLE;
        if (r_gnt == PORT_D) begin
          d_done = 1'b1;
          d_err  = ~r_legal;
        end else begin
          i_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a byte memory model.
// Honours MEM_ARB_RR_EN for the expected tie-break order.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic        CLK;
  logic        Reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tbMem  [0:MEM_BYTES-1];
  logic [7:0] refMem [0:MEM_BYTES-1];
  bit         memInit = 1'b0;

  logic        modelLast;
  logic [31:0] curIRdata;
  logic [31:0] lastIData;
  logic [31:0] lastDData;
  logic        lastDErr;

  typedef struct {
    bit          useD;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs [10];

  mem_arbiter dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_err     (d_err),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory: preload once, then write little-endian on the rising edge.
  always @(posedge CLK) begin
    if (!memInit) begin
      for (int k = 0; k < MEM_BYTES; k++) tbMem[k] <= 8'h00;
      tbMem[16'h010] <= 8'h44; tbMem[16'h011] <= 8'h33; tbMem[16'h012] <= 8'h22; tbMem[16'h013] <= 8'h11;
      tbMem[16'h040] <= 8'h88; tbMem[16'h041] <= 8'h77; tbMem[16'h042] <= 8'h66; tbMem[16'h043] <= 8'h55;
      for (int k = 16'h3FC; k < MEM_BYTES; k++) tbMem[k] <= 8'hA5;
      memInit <= 1'b1;
    end else if (mem_rw && mem_addr <= 32'd1020) begin
      tbMem[mem_addr[9:0]]         <= mem_wdata[7:0];
      tbMem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      tbMem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
      tbMem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
    end
  end

  // Combinational read port of the memory.
  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr <= 32'd1020) begin
      mem_rdata = {tbMem[mem_addr[9:0] + 10'd3], tbMem[mem_addr[9:0] + 10'd2],
                   tbMem[mem_addr[9:0] + 10'd1], tbMem[mem_addr[9:0]]};
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isLegal(input logic [31:0] a);
    return a <= 32'(MEM_BYTES - 4);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (!isLegal(a)) return 32'h0;
    return {refMem[a[9:0] + 10'd3], refMem[a[9:0] + 10'd2], refMem[a[9:0] + 10'd1], refMem[a[9:0]]};
  endfunction

  // Returns 1 when D should win the given request pattern.
  function automatic logic modelPick(input bit iq, input bit dq);
    if (iq && dq) begin
`ifdef MEM_ARB_RR_EN
      return ~modelLast;
`else
      return 1'b1;
`endif
    end
    return dq;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_iRdata"}, i_rdata, 32'h0);
    checkOutput({tag, "_dRdata"}, d_rdata, 32'h0);
    checkOutput({tag, "_flags"}, 32'({mem_rw, i_done, d_done, d_err}), 32'h0);
    checkOutput({tag, "_memAddr"}, mem_addr, 32'h0);
    checkOutput({tag, "_memWdata"}, mem_wdata, 32'h0);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_rw = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    checkResetOutputs("reset");
    Reset = 1'b0;
    modelLast = PORT_I;
    curIRdata = 32'h0;
  endtask

  // One request round: I and/or D raised together, each held until its done.
  task automatic applyStimulus(input bit useI, input bit useD, input logic [31:0] iAddr,
                               input bit dRw, input logic [31:0] dAddr, input logic [31:0] dWdata);
    logic        firstD;
    bit          bothReq;
    logic [31:0] expI, expD;
    logic        expErr;
    int          expIT, expDT, expWrites;
    int          t, gotIT, gotDT, writes, iPulses, dPulses;

    bothReq = useI && useD;
    firstD  = modelPick(useI, useD);
    expI = 32'h0; expD = 32'h0; expErr = 1'b0; expIT = -1; expDT = -1;
    expWrites = (useD && dRw && isLegal(dAddr)) ? 1 : 0;
    for (int s = 0; s < 2; s++) begin
      logic doD;
      doD = (s == 0) ? firstD : !firstD;
      if (s == 0 || bothReq) begin
        if (doD) begin
          expDT  = (s == 0) ? 2 : 5;
          expErr = !isLegal(dAddr);
          expD   = refRead(dAddr);
          if (dRw && isLegal(dAddr)) begin
            for (int b = 0; b < 4; b++) refMem[dAddr[9:0] + 10'(b)] = dWdata[8*b +: 8];
          end
        end else begin
          expIT = (s == 0) ? 2 : 5;
          expI  = refRead(iAddr);
        end
        modelLast = doD;
      end
    end

    @(negedge CLK);
    i_req = useI; i_addr = iAddr;
    d_req = useD; d_rw = dRw; d_addr = dAddr; d_wdata = dWdata;
    t = 0; gotIT = -1; gotDT = -1; writes = 0; iPulses = 0; dPulses = 0;
    while (((useI && gotIT < 0) || (useD && gotDT < 0)) && t < 12) begin
      @(negedge CLK);
      t++;
      if (mem_rw) writes++;
      checkOutput("doneExclusive", 32'(i_done & d_done), 32'h0);
      if (i_done) begin
        iPulses++;
        if (gotIT < 0) begin
          gotIT     = t;
          lastIData = i_rdata;
          checkOutput("iNoErr", 32'(d_err), 32'h0);
          curIRdata = expI;
          i_req     = 1'b0;
        end
      end
      if (d_done) begin
        dPulses++;
        if (gotDT < 0) begin
          gotDT     = t;
          lastDData = d_rdata;
          lastDErr  = d_err;
          checkOutput("iRdataHeld", i_rdata, curIRdata);
          d_req     = 1'b0;
        end
      end
      if (i_done || d_done) checkOutput("respPinsIdle", mem_addr | mem_wdata | 32'(mem_rw), 32'h0);
    end
    i_req = 1'b0;
    d_req = 1'b0;

    if (useI) begin
      checkOutput("iLatency", 32'(gotIT), 32'(expIT));
      checkOutput("iRdata", lastIData, expI);
    end
    if (useD) begin
      checkOutput("dLatency", 32'(gotDT), 32'(expDT));
      checkOutput("dErr", 32'(lastDErr), 32'(expErr));
      if (!dRw) checkOutput("dRdata", lastDData, expD);
    end
    checkOutput("memWrites", 32'(writes), 32'(expWrites));
    checkOutput("donePulses", 32'({iPulses[7:0], dPulses[7:0]}), 32'({8'(useI ? 1 : 0), 8'(useD ? 1 : 0)}));
  endtask

  function automatic logic [31:0] randAddr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5) return 32'h80 + {22'h0, 8'($urandom_range(0, 63)), 2'b00};
    if (sel <= 7) return 32'($urandom_range(0, 1020));
    if (sel == 8) return 32'($urandom_range(1021, 1040));
    return $urandom;
  endfunction

  initial begin
    int mismatches;
    int doneCount;

    for (int k = 0; k < MEM_BYTES; k++) refMem[k] = 8'h00;
    refMem[16'h010] = 8'h44; refMem[16'h011] = 8'h33; refMem[16'h012] = 8'h22; refMem[16'h013] = 8'h11;
    refMem[16'h040] = 8'h88; refMem[16'h041] = 8'h77; refMem[16'h042] = 8'h66; refMem[16'h043] = 8'h55;
    for (int k = 16'h3FC; k < MEM_BYTES; k++) refMem[k] = 8'hA5;

    //            useD  rw    addr          wdata         expData       expErr
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        32'h1122_3344, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0021, 32'h0,        32'h00DE_ADBE, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_03FD, 32'h1234_5678, 32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0,        1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,        32'hA5A5_A5A5, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_03FD, 32'h0,        32'h0,        1'b0};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 1'b0};

    doReset();

    $display("[TB] tie rounds from reset");
    for (int r = 0; r < 4; r++) applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 32'h3FC, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h3FC, 1'b0, 32'h10, 32'h0);

    $display("[TB] directed vector table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(!vecs[v].useD, vecs[v].useD, vecs[v].addr, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      if (vecs[v].useD) begin
        checkOutput($sformatf("vec%0d_dErr", v), 32'(lastDErr), 32'(vecs[v].expErr));
        if (!vecs[v].rw) checkOutput($sformatf("vec%0d_dRdata", v), lastDData, vecs[v].expData);
      end else begin
        checkOutput($sformatf("vec%0d_iRdata", v), lastIData, vecs[v].expData);
      end
    end
    checkOutput("memBytes20", {tbMem[16'h023], tbMem[16'h022], tbMem[16'h021], tbMem[16'h020]}, 32'hDEAD_BEEF);
    checkOutput("memByte20", 32'(tbMem[16'h020]), 32'hEF);
    checkOutput("memTopUnchanged", {tbMem[16'h3FF], tbMem[16'h3FE], tbMem[16'h3FD], tbMem[16'h3FC]}, 32'hA5A5_A5A5);

    $display("[TB] reset during SERVE of a write");
    @(negedge CLK);
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    @(negedge CLK);
    checkOutput("abortServeWrite", 32'(mem_rw), 32'h1);
    Reset = 1'b1;
    #1;
    checkOutput("abortMemRwDrop", 32'(mem_rw), 32'h0);
    checkResetOutputs("abort");
    d_req = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    modelLast = PORT_I;
    curIRdata = 32'h0;
    checkOutput("abortMemUnchanged", {tbMem[16'h043], tbMem[16'h042], tbMem[16'h041], tbMem[16'h040]}, 32'h5566_7788);
    doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (d_done || i_done) doneCount++;
    end
    checkOutput("abortNoDone", 32'(doneCount), 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      applyStimulus(mode != 1, mode != 0, randAddr(), 1'($urandom_range(0, 1)), randAddr(), $urandom);
    end

    mismatches = 0;
    for (int k = 0; k < MEM_BYTES; k++) if (tbMem[k] !== refMem[k]) mismatches++;
    checkOutput("memImage", 32'(mismatches), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
